serial_load_controller: RTL and testbench

SERIAL_LOAD_CONTROLLER -- requirements
Module: serial_load_controller

---
 rtl/serial_load_pkg.sv | 36 +++
 rtl/serial_load_if.sv | 29 ++
 rtl/serial_load_shifter.sv | 50 +++++
 rtl/serial_load_controller.sv | 126 ++++++++++++
 tb/tb_serial_load_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/serial_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_pkg
// Brief    : Shared widths, state encodings and parity helper for the serial
//            load controller. Optional parity build: SERIAL_LOAD_PARITY_EN.
// Revision : 1.0
// ============================================================================
package serial_load_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = $clog2(DATA_W);

    // Counter value at which the final data bit is being accepted.
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOAD   = 2'd2
`ifdef SERIAL_LOAD_PARITY_EN
        ,
        ST_PARITY = 2'd3
`endif
    } state_t;

`ifdef SERIAL_LOAD_PARITY_EN
    // Even parity: data plus parity bit must carry an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] i_data,
                                            input logic              i_par);
        return ~(^{i_data, i_par});
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/serial_load_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_if
// Brief    : Serial input / parallel load bus of the serial load controller.
// Revision : 1.0
// ============================================================================
interface serial_load_if;
    import serial_load_pkg::*;

    logic              SerIn;
    logic              SerValid;
    logic              Abort;
    logic [DATA_W-1:0] ParOut;
    logic              EnbarOut;
    logic              Busy;
    logic              ParityErr;

    modport master (
        output SerIn, SerValid, Abort,
        input  ParOut, EnbarOut, Busy, ParityErr
    );

    modport slave (
        input  SerIn, SerValid, Abort,
        output ParOut, EnbarOut, Busy, ParityErr
    );

endinterface
`default_nettype wire

// File: rtl/serial_load_shifter.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_shifter
// Brief    : Indexed shift register and bit counter, updated on falling edge.
// Revision : 1.0
// ============================================================================
module serial_load_shifter
    import serial_load_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clr_cnt,
    input  wire logic              i_shift_en,
    input  wire logic              i_bit,
    output logic [DATA_W-1:0]      o_load_data,
    output logic [CNT_W-1:0]       o_cnt
);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_shift_next;

    always_comb begin
        w_shift_next                    = r_shift;
        w_shift_next[r_cnt[IDX_W-1:0]]  = i_bit;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clr_cnt) begin
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // With parity the byte is complete before the parity bit arrives; without
    // it the last data bit must be merged in on the same edge it is accepted.
`ifdef SERIAL_LOAD_PARITY_EN
    assign o_load_data = r_shift;
`else
    assign o_load_data = w_shift_next;
`endif
    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/serial_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_controller
// Brief    : Assembles an LSB-first serial byte and pulses an active-low load
//            enable for one ClkN period. Parity build: SERIAL_LOAD_PARITY_EN.
// Revision : 1.0
// ============================================================================
module serial_load_controller
    import serial_load_pkg::*;
(
    input  wire logic    ClkN,
    input  wire logic    Clr,
    serial_load_if.slave bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_par_out;
    logic              r_enbar;
    logic              r_busy;

    logic              w_in_frame;
    logic              w_shift_en;
    logic              w_clr_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_load_data;

    assign w_in_frame = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
    assign w_shift_en = w_in_frame && !bus.Abort && bus.SerValid;

    // Counter restarts after a load, on abort, and once the parity bit is seen.
`ifdef SERIAL_LOAD_PARITY_EN
    assign w_clr_cnt = (r_state == ST_LOAD)
                     || (bus.Abort && (r_state != ST_LOAD))
                     || ((r_state == ST_PARITY) && bus.SerValid);
`else
    assign w_clr_cnt = (r_state == ST_LOAD)
                     || (bus.Abort && (r_state != ST_LOAD));
`endif

    serial_load_shifter u_shifter (
        .clk         (ClkN),
        .rst         (Clr),
        .i_clr_cnt   (w_clr_cnt),
        .i_shift_en  (w_shift_en),
        .i_bit       (bus.SerIn),
        .o_load_data (w_load_data),
        .o_cnt       (w_cnt)
    );

`ifdef SERIAL_LOAD_PARITY_EN
    logic r_parity_err;
`endif

    always_ff @(negedge ClkN) begin
        if (Clr) begin
            r_state   <= ST_IDLE;
            r_par_out <= '0;
            r_enbar   <= 1'b1;
            r_busy    <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_LOAD_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_SHIFT: begin
                    if (bus.Abort) begin
                        r_state <= ST_IDLE;
                    end else if (bus.SerValid) begin
                        if (w_cnt == c_LAST_CNT) begin
`ifdef SERIAL_LOAD_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_LOAD;
                            r_par_out <= w_load_data;
                            r_enbar   <= 1'b0;
                            r_busy    <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
`ifdef SERIAL_LOAD_PARITY_EN
                ST_PARITY: begin
                    if (bus.Abort) begin
                        r_state <= ST_IDLE;
                    end else if (bus.SerValid) begin
                        if (even_parity_ok(w_load_data, bus.SerIn)) begin
                            r_state   <= ST_LOAD;
                            r_par_out <= w_load_data;
                            r_enbar   <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_parity_err <= 1'b1;
                        end
                    end
                end
`endif
                // Load always completes; Abort and SerValid are ignored here.
                ST_LOAD: begin
                    r_state <= ST_IDLE;
                    r_enbar <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ParOut   = r_par_out;
    assign bus.EnbarOut = r_enbar;
    assign bus.Busy     = r_busy;
`ifdef SERIAL_LOAD_PARITY_EN
    assign bus.ParityErr = r_parity_err;
`else
    assign bus.ParityErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_load_controller
// Brief    : Directed plus randomized bench with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_serial_load_controller;
    import serial_load_pkg::*;

`ifdef SERIAL_LOAD_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    logic ClkN;
    logic Clr;
    serial_load_if bus();

    serial_load_controller dut (
        .ClkN (ClkN),
        .Clr  (Clr),
        .bus  (bus)
    );

    initial ClkN = 1'b0;
    always #5 ClkN = ~ClkN;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: collects accepted bits of a frame in a queue.
    bit         mq[$];
    logic [7:0] m_par  = 8'h00;
    bit         m_load = 1'b0;
    bit         m_err  = 1'b0;
    int         m_ones;
    logic [7:0] m_byte;

    always @(negedge ClkN) begin
        if (Clr) begin
            mq.delete();
            m_par  = 8'h00;
            m_load = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_load) begin
                m_load = 1'b0;
                mq.delete();
            end else if (bus.Abort) begin
                mq.delete();
            end else if (bus.SerValid) begin
                mq.push_back(bus.SerIn);
                if (mq.size() == FRAME_BITS) begin
                    m_ones = 0;
                    for (int i = 0; i < FRAME_BITS; i++) m_ones += int'(mq[i]);
                    for (int i = 0; i < 8; i++) m_byte[i] = mq[i];
                    if (FRAME_BITS == 8 || (m_ones % 2) == 0) begin
                        m_par  = m_byte;
                        m_load = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    mq.delete();
                end
            end
        end
    end

    always @(posedge ClkN) begin
        if (chk_en) begin
            check("cyc_parout",   bus.ParOut,           m_par);
            check("cyc_enbar",    8'(bus.EnbarOut),     8'(!m_load));
            check("cyc_busy",     8'(bus.Busy),         8'(m_load));
            check("cyc_parerr",   8'(bus.ParityErr),    8'(m_err));
        end
    end

    task automatic drive(input logic clr, input logic v, input logic b, input logic ab);
        @(posedge ClkN);
        #1;
        Clr          = clr;
        bus.SerValid = v;
        bus.SerIn    = b;
        bus.Abort    = ab;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_at, input int gap_len,
                             input logic par_flip);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) idle(gap_len);
            drive(1'b0, 1'b1, b[i], 1'b0);
        end
`ifdef SERIAL_LOAD_PARITY_EN
        drive(1'b0, 1'b1, (^b) ^ par_flip, 1'b0);
`else
        if (par_flip) idle(0);
`endif
    endtask

    initial begin
        Clr          = 1'b1;
        bus.SerValid = 1'b0;
        bus.SerIn    = 1'b0;
        bus.Abort    = 1'b0;

        // Reset held for two cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("rst_parout", bus.ParOut, 8'h00);
        check("rst_enbar",  8'(bus.EnbarOut),  8'h01);
        check("rst_busy",   8'(bus.Busy),      8'h00);
        check("rst_parerr", 8'(bus.ParityErr), 8'h00);

        // Frame 0xA5 on consecutive cycles.
        send_byte(8'hA5, -1, 0, 1'b0);
        idle(1);
        check("frame_parout", bus.ParOut, 8'hA5);
        check("frame_enbar",  8'(bus.EnbarOut), 8'h00);
        check("frame_busy",   8'(bus.Busy),     8'h01);
        check("model_frame",  m_par,            8'hA5);
        idle(1);
        check("frame_enbar_end", 8'(bus.EnbarOut), 8'h01);
        check("frame_busy_end",  8'(bus.Busy),     8'h00);

        // Same byte with a three-cycle gap after the fourth bit.
        idle(2);
        send_byte(8'hA5, 4, 3, 1'b0);
        idle(1);
        check("gap_parout", bus.ParOut, 8'hA5);
        check("gap_enbar",  8'(bus.EnbarOut), 8'h00);
        idle(2);

        // Abort after five bits, then a full 0x3C.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        check("abort_held",  bus.ParOut, 8'hA5);
        check("abort_enbar", 8'(bus.EnbarOut), 8'h01);
        send_byte(8'h3C, -1, 0, 1'b0);
        idle(1);
        check("abort_parout", bus.ParOut, 8'h3C);
        check("abort_enbar2", 8'(bus.EnbarOut), 8'h00);
        idle(2);

`ifdef SERIAL_LOAD_PARITY_EN
        // Bad parity: error pulse, no load, ParOut unchanged.
        send_byte(8'hA5, -1, 0, 1'b1);
        idle(1);
        check("perr_pulse",  8'(bus.ParityErr), 8'h01);
        check("perr_enbar",  8'(bus.EnbarOut),  8'h01);
        check("perr_parout", bus.ParOut,        8'h3C);
        idle(1);
        check("perr_pulse_end", 8'(bus.ParityErr), 8'h00);
        idle(1);
`endif

        // Clr asserted during the load cycle.
        send_byte(8'hA5, -1, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("clr_in_load", 8'(bus.EnbarOut), 8'h00);
        idle(1);
        check("clr_enbar",  8'(bus.EnbarOut), 8'h01);
        check("clr_parout", bus.ParOut,       8'h00);
        check("clr_busy",   8'(bus.Busy),     8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            drive(r == 0, $urandom_range(0, 3) != 0, 1'($urandom), (r >= 1) && (r <= 4));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
